// File: rtl/avl_stream_pkt_arb_if.sv
// Avalon-ST packet stream bundle used on every port of avl_stream_pkt_arb.
// almost_full is carried for the neighbouring blocks and is not in any modport.

`define AVL_STREAM_PKT_IF(w, ch) avl_stream_if #(.WIDTH(w), .MAX_CH(ch))

interface avl_stream_if #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned MAX_CH = 16
);
  localparam int unsigned CH_W    = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int unsigned EMPTY_W = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;

  logic [WIDTH-1:0]   data;
  logic               valid;
  logic               ready;
  logic               sop;
  logic               eop;
  logic [EMPTY_W-1:0] empty;
  logic [CH_W-1:0]    channel;
  logic               almost_full;

  modport tx (output data, valid, sop, eop, empty, channel, input ready);
  modport rx (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/avl_stream_pkt_arb.sv
// Packet-level round-robin merge of NUM_IN Avalon-ST inputs onto one output.
// A packet, once started, owns the output until its eop beat is accepted.
// The winning input index is carried on out_if.channel.

module avl_stream_pkt_arb #(
  parameter int unsigned WIDTH  = 512,
  parameter int unsigned NUM_IN = 3,
  localparam int unsigned CH_MIN = 16,
  parameter int unsigned MAX_CH = CH_MIN
) (
  input  logic     clk,
  input  logic     rst,
  avl_stream_if.rx in_if [NUM_IN],
  avl_stream_if.tx out_if,
  output logic     proto_err
);

  localparam int unsigned IDX_W   = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
  localparam int unsigned CH_W    = (MAX_CH > 1) ? $clog2(MAX_CH) : 1;
  localparam int unsigned EMPTY_W = (WIDTH > 8) ? $clog2(WIDTH / 8) : 1;

  typedef enum logic {
    UNLOCKED,
    LOCKED
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   lock_idx;
  logic [IDX_W-1:0]   rr_ptr;

  // flattened view of the input interfaces
  logic [NUM_IN-1:0]  in_valid;
  logic [NUM_IN-1:0]  in_sop;
  logic [NUM_IN-1:0]  in_eop;
  logic [NUM_IN-1:0]  in_ready;
  logic [WIDTH-1:0]   in_data  [NUM_IN];
  logic [EMPTY_W-1:0] in_empty [NUM_IN];

  // arbitration
  logic [IDX_W-1:0]   grant;
  logic               grant_vld;
  logic               can_load;
  logic               accept;
  logic               sel_valid;
  logic               sel_sop;
  logic               sel_eop;
  logic [WIDTH-1:0]   sel_data;
  logic [EMPTY_W-1:0] sel_empty;
  logic [IDX_W-1:0]   next_ptr;

  // output register
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic               out_sop;
  logic               out_eop;
  logic [EMPTY_W-1:0] out_empty;
  logic [CH_W-1:0]    out_channel;

  for (genvar g = 0; g < NUM_IN; g++) begin : g_in
    assign in_valid[g]    = in_if[g].valid;
    assign in_sop[g]      = in_if[g].sop;
    assign in_eop[g]      = in_if[g].eop;
    assign in_data[g]     = in_if[g].data;
    assign in_empty[g]    = in_if[g].empty;
    assign in_if[g].ready = in_ready[g];
  end

  assign out_if.valid   = out_valid;
  assign out_if.data    = out_data;
  assign out_if.sop     = out_sop;
  assign out_if.eop     = out_eop;
  assign out_if.empty   = out_empty;
  assign out_if.channel = out_channel;

  assign can_load = !out_valid || out_if.ready;

  // Grant: locked input while a packet is open, else first valid input from rr_ptr
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    if (state == LOCKED) begin
      grant     = lock_idx;
      grant_vld = 1'b1;
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NUM_IN) begin
          idx = idx - NUM_IN;
        end
        if (!grant_vld && in_valid[idx]) begin
          grant     = idx[IDX_W-1:0];
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Beat selection from the granted input and the handshake it produces
  always_comb begin
    sel_valid = in_valid[grant];
    sel_sop   = in_sop[grant];
    sel_eop   = in_eop[grant];
    sel_data  = in_data[grant];
    sel_empty = in_empty[grant];
    accept    = !rst && grant_vld && sel_valid && can_load;
    next_ptr  = (grant == IDX_W'(NUM_IN - 1)) ? '0 : grant + IDX_W'(1);
  end

  // Ready goes only to the granted input, and never while in reset
  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      in_ready[i] = !rst && grant_vld && can_load && (grant == IDX_W'(i));
    end
  end

  // Packet lock FSM, round-robin pointer, output valid and sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= UNLOCKED;
      lock_idx  <= '0;
      rr_ptr    <= '0;
      out_valid <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
      end else if (out_if.ready) begin
        out_valid <= 1'b0;
      end

      if (accept) begin
        if (sel_eop) begin
          rr_ptr <= next_ptr;
        end
        unique case (state)
          UNLOCKED: begin
            if (!sel_sop) begin
              proto_err <= 1'b1;
            end
            if (!sel_eop) begin
              state    <= LOCKED;
              lock_idx <= grant;
            end
          end
          LOCKED: begin
            if (sel_sop) begin
              proto_err <= 1'b1;
            end
            if (sel_eop) begin
              state <= UNLOCKED;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  // Output payload; contents are don't-care whenever out_valid is low
  always_ff @(posedge clk) begin
    if (accept) begin
      out_data    <= sel_data;
      out_sop     <= sel_sop;
      out_eop     <= sel_eop;
      out_empty   <= sel_empty;
      out_channel <= CH_W'(grant);
    end
  end

endmodule

// File: tb/tb_avl_stream_pkt_arb.sv
// Directed bench for avl_stream_pkt_arb: three packet sources, one output monitor.

module tb_avl_stream_pkt_arb;

  localparam int unsigned W  = 32;
  localparam int unsigned NI = 3;
  localparam int unsigned MC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic proto_err;
  logic out_ready = 1'b1;

  logic [NI-1:0]  en       = '0;
  logic [NI-1:0]  sop_flip = '0;
  logic [NI-1:0]  rdy;
  int unsigned    len [NI] = '{3, 3, 3};

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;

  typedef struct {
    logic [37:0] word;
    int          cyc;
  } beat_t;
  beat_t mon_q[$];

  avl_stream_if #(.WIDTH(W), .MAX_CH(MC)) in_if [NI] ();
  avl_stream_if #(.WIDTH(W), .MAX_CH(MC)) out_if ();

  avl_stream_pkt_arb #(.WIDTH(W), .NUM_IN(NI), .MAX_CH(MC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (in_if),
    .out_if    (out_if),
    .proto_err (proto_err)
  );

  always #5 clk = ~clk;

  // Sources: fixed-length packets, data = {src, pkt#, beat#}, advance on handshake
  for (genvar g = 0; g < NI; g++) begin : g_src
    int unsigned bc  = 0;
    logic [7:0]  pkt = '0;
    assign in_if[g].valid       = en[g];
    assign in_if[g].sop         = (bc == 0) ^ sop_flip[g];
    assign in_if[g].eop         = (bc == len[g] - 1);
    assign in_if[g].data        = {8'(g), pkt, 16'(bc)};
    assign in_if[g].empty       = 2'(g + 1);
    assign in_if[g].channel     = '0;
    assign in_if[g].almost_full = 1'b0;
    assign rdy[g]               = in_if[g].ready;
    always @(posedge clk) begin
      if (rst) begin
        bc  <= 0;
        pkt <= '0;
      end else if (en[g] && rdy[g]) begin
        if (bc == len[g] - 1) begin
          bc  <= 0;
          pkt <= pkt + 8'd1;
        end else begin
          bc <= bc + 1;
        end
      end
    end
  end

  assign out_if.ready       = out_ready;
  assign out_if.almost_full = 1'b0;

  logic [37:0] out_word;
  assign out_word = {out_if.empty, out_if.channel, out_if.sop, out_if.eop, out_if.data};

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!rst && out_if.valid && out_if.ready) begin
      mon_q.push_back('{word: out_word, cyc: cyc_cnt});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [37:0] bw(input int unsigned ch, input logic sop, input logic eop,
                                     input int unsigned pkt, input int unsigned b);
    return {2'(ch + 1), 2'(ch), sop, eop, 8'(ch), 8'(pkt), 16'(b)};
  endfunction

  function automatic logic [37:0] mon_word(input int unsigned i);
    if (i < mon_q.size()) return mon_q[i].word;
    return '1;
  endfunction

  function automatic int mon_cyc(input int unsigned i);
    if (i < mon_q.size()) return mon_q[i].cyc;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = '0;
    sop_flip  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < int'(NI); i++) len[i] = 3;
    tick();
    tick();
  endtask

  initial begin
    int unsigned base;

    // reset state, with every source requesting
    do_reset();
    en = '1;
    @(negedge clk);
    check("rst_valid", 64'(out_if.valid), 64'(0));
    check("rst_ready", 64'(rdy), 64'(0));
    check("rst_err", 64'(proto_err), 64'(0));
    check("rst_rr", 64'(dut.rr_ptr), 64'(0));
    tick();

    // all inputs busy with 3-beat packets: round robin, back to back
    rst  = 1'b0;
    base = mon_q.size();
    repeat (20) tick();
    check("rr_count", 64'(mon_q.size() - base >= 18), 64'(1));
    for (int unsigned k = 0; k < 18; k++) begin
      check("rr_beat", 64'(mon_word(base + k)),
            64'(bw((k / 3) % 3, (k % 3) == 0, (k % 3) == 2, k / 9, k % 3)));
      check("rr_contig", 64'(mon_cyc(base + k) - mon_cyc(base)), 64'(k));
    end
    check("rr_err", 64'(proto_err), 64'(0));

    // bubble inside a locked packet must not let input 0 in
    do_reset();
    len[0] = 1;
    len[1] = 2;
    en[1]  = 1'b1;
    rst    = 1'b0;
    base   = mon_q.size();
    @(negedge clk);
    check("bub_first_rdy", 64'(rdy), 64'(3'b010));
    tick();
    en[1] = 1'b0;
    en[0] = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("bub_gap_rdy", 64'(rdy), 64'(3'b010));
      tick();
    end
    en[1] = 1'b1;
    @(negedge clk);
    check("bub_eop_rdy", 64'(rdy), 64'(3'b010));
    tick();
    @(negedge clk);
    check("bub_release_rdy", 64'(rdy), 64'(3'b001));
    repeat (3) tick();
    check("bub_beat0", 64'(mon_word(base)),     64'(bw(1, 1, 0, 0, 0)));
    check("bub_beat1", 64'(mon_word(base + 1)), 64'(bw(1, 0, 1, 0, 1)));
    check("bub_beat2", 64'(mon_word(base + 2)), 64'(bw(0, 1, 1, 0, 0)));

    // output backpressure mid-packet
    do_reset();
    en   = '1;
    rst  = 1'b0;
    base = mon_q.size();
    tick();
    tick();
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_rdy", 64'(rdy), 64'(0));
      check("bp_valid", 64'(out_if.valid), 64'(1));
      check("bp_hold", 64'(out_word), 64'(bw(0, 0, 0, 0, 1)));
      tick();
    end
    out_ready = 1'b1;
    repeat (6) tick();
    check("bp_beat0", 64'(mon_word(base)),     64'(bw(0, 1, 0, 0, 0)));
    check("bp_beat1", 64'(mon_word(base + 1)), 64'(bw(0, 0, 0, 0, 1)));
    check("bp_beat2", 64'(mon_word(base + 2)), 64'(bw(0, 0, 1, 0, 2)));
    check("bp_beat3", 64'(mon_word(base + 3)), 64'(bw(1, 1, 0, 0, 0)));

    // single-beat packets from input 2 alone
    do_reset();
    en[2]  = 1'b1;
    len[2] = 1;
    rst    = 1'b0;
    for (int unsigned c = 0; c < 4; c++) begin
      @(negedge clk);
      check("sb_rdy", 64'(rdy), 64'(3'b100));
      tick();
      check("sb_rr", 64'(dut.rr_ptr), 64'(0));
      check("sb_out", 64'(out_word), 64'(bw(2, 1, 1, c, 0)));
      check("sb_valid", 64'(out_if.valid), 64'(1));
    end

    // second sop inside an open packet
    do_reset();
    en[0] = 1'b1;
    rst   = 1'b0;
    base  = mon_q.size();
    tick();
    sop_flip[0] = 1'b1;
    @(negedge clk);
    check("sop2_err_before", 64'(proto_err), 64'(0));
    tick();
    sop_flip[0] = 1'b0;
    @(negedge clk);
    check("sop2_err_set", 64'(proto_err), 64'(1));
    tick();
    en[0] = 1'b0;
    repeat (3) tick();
    check("sop2_err_sticky", 64'(proto_err), 64'(1));
    check("sop2_beat0", 64'(mon_word(base)),     64'(bw(0, 1, 0, 0, 0)));
    check("sop2_beat1", 64'(mon_word(base + 1)), 64'(bw(0, 1, 0, 0, 1)));
    check("sop2_beat2", 64'(mon_word(base + 2)), 64'(bw(0, 0, 1, 0, 2)));

    // missing sop on a packet start
    do_reset();
    @(negedge clk);
    check("nosop_err_cleared", 64'(proto_err), 64'(0));
    en[0]       = 1'b1;
    sop_flip[0] = 1'b1;
    rst         = 1'b0;
    tick();
    sop_flip[0] = 1'b0;
    @(negedge clk);
    check("nosop_err_set", 64'(proto_err), 64'(1));
    check("nosop_fwd", 64'(out_word), 64'(bw(0, 0, 0, 0, 0)));

    // reset while locked with a beat in the output register
    do_reset();
    en[0]  = 1'b1;
    en[1]  = 1'b1;
    len[0] = 1;
    rst    = 1'b0;
    @(negedge clk);
    check("rl_rdy_rr0", 64'(rdy), 64'(3'b001));
    tick();
    @(negedge clk);
    check("rl_rdy_rr1", 64'(rdy), 64'(3'b010));
    tick();
    check("rl_locked_valid", 64'(out_if.valid), 64'(1));
    rst = 1'b1;
    @(negedge clk);
    check("rl_rst_rdy_now", 64'(rdy), 64'(0));
    tick();
    @(negedge clk);
    check("rl_rst_valid", 64'(out_if.valid), 64'(0));
    check("rl_rst_rdy", 64'(rdy), 64'(0));
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rl_tie_rdy", 64'(rdy), 64'(3'b001));
    tick();
    check("rl_tie_out", 64'(out_word), 64'(bw(0, 1, 1, 0, 0)));
    check("rl_err", 64'(proto_err), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/avl_stream_pkt_arb.md
AVL_STREAM_PKT_ARB -- requirements
Module: avl_stream_pkt_arb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 512, giving the data width of every stream.
REQ-002 The block SHALL have parameter NUM_IN, default 3, giving the number of input streams; legal range is 2..CH_MIN.
REQ-003 The block SHALL have parameter MAX_CH, default CH_MIN, giving the channel range of the output stream; it SHALL be at least NUM_IN.
REQ-004 Port clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-005 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 Port in_if[NUM_IN], avl_stream_if.rx array, WIDTH: the input streams; data, valid, sop, eop and empty are used, and ready is driven.
REQ-007 Port out_if, avl_stream_if.tx, WIDTH/MAX_CH: the merged output stream; data, valid, sop, eop, empty and channel are driven, and ready is used.
REQ-008 Port proto_err, output, 1 bit: sticky flag for a protocol error.
REQ-009 The block SHALL NOT drive or use almost_full on any interface; the instantiating design SHALL declare the interfaces with AVL_STREAM_PKT_IF.

Function
REQ-010 The block SHALL merge the NUM_IN input streams into one output stream and SHALL never interleave beats from two different packets.
REQ-011 The block SHALL keep one output register stage; a beat accepted on cycle N SHALL appear on out_if on cycle N+1.
REQ-012 can_load SHALL equal (!out_if.valid || out_if.ready).
REQ-013 in_if[i].ready SHALL equal (grant==i && grant_vld && can_load) and SHALL be low for every non-granted input.
REQ-014 A beat from input i SHALL be accepted when in_if[i].valid && in_if[i].ready.
REQ-015 On acceptance, the block SHALL load data, sop, eop and empty unchanged into the output register, SHALL load channel with i zero-extended, and SHALL set out_if.valid.
REQ-016 When out_if.valid && out_if.ready and no beat is accepted in the same cycle, out_if.valid SHALL clear on the next cycle.
REQ-017 The block SHALL hold the output register stable while out_if.valid && !out_if.ready.
REQ-018 The block SHALL have two states, UNLOCKED and LOCKED, with a lock_idx register.
REQ-019 In UNLOCKED, grant SHALL be the first i with in_if[i].valid, searching rr_ptr, rr_ptr+1, ... modulo NUM_IN; grant_vld SHALL be set if any input is valid.
REQ-020 In UNLOCKED, grant SHALL be combinational, so a valid input SHALL be accepted in the same cycle if can_load is true.
REQ-021 UNLOCKED -> LOCKED SHALL occur on an accepted beat with eop=0; lock_idx SHALL then be loaded with the grant.
REQ-022 In LOCKED, grant SHALL be lock_idx and grant_vld SHALL be 1.
REQ-023 In LOCKED, other inputs SHALL be ignored even when the locked input deasserts valid; that gap is a bubble, not a release.
REQ-024 LOCKED -> UNLOCKED SHALL occur on an accepted beat with eop=1.
REQ-025 rr_ptr SHALL update only on an accepted eop=1 beat from input g, to (g+1) mod NUM_IN.
REQ-026 A single-beat packet (sop=1, eop=1) SHALL NOT enter LOCKED and SHALL advance rr_ptr.
REQ-027 proto_err SHALL set, and stay set until rst, on an accepted sop=1 beat while LOCKED.
REQ-028 proto_err SHALL set, and stay set until rst, on an accepted sop=0 beat while UNLOCKED.
REQ-029 A beat that sets proto_err SHALL still be forwarded, and the state transitions SHALL follow eop as normal.
REQ-030 When only one input is valid, that input SHALL be granted regardless of rr_ptr.
REQ-031 With all inputs continuously valid and out_if.ready=1, packets SHALL be served strictly 0,1,2,0,... at 1 beat per cycle, with no idle cycle between packets.

Reset
REQ-032 While rst=1, out_if.valid SHALL be 0, state SHALL be UNLOCKED, rr_ptr SHALL be 0, lock_idx SHALL be 0, proto_err SHALL be 0, and every in_if[i].ready SHALL be 0.
REQ-033 Reset mid-packet SHALL discard the output register and the lock; truncating the upstream packet is the source's responsibility.
REQ-034 out_if.data, empty and channel SHALL be don't-care while out_if.valid=0.

Verification
REQ-035 Stimulus: inputs 0, 1 and 2 each present 3-beat packets continuously, with out_if.ready=1. Required response: channel sequence 0,0,0,1,1,1,2,2,2,0..., beats contiguous, proto_err=0.
REQ-036 Stimulus: input 1 sends sop, then valid drops for 4 cycles, then eop; input 0 is valid throughout. Required response: no input-0 beat appears between the input-1 sop and eop, and input 0 is granted the cycle after the eop is accepted.
REQ-037 Stimulus: out_if.ready is held low for 5 cycles mid-packet. Required response: out_if data, sop, eop and channel are stable; in_if ready=0 for all inputs; no beat is lost or duplicated.
REQ-038 Stimulus: only input 2 sends single-beat packets, rr_ptr=0. Required response: each is accepted the same cycle it is presented (given can_load), channel=2, and rr_ptr becomes 0 after each.
REQ-039 Stimulus: input 0 sends sop, then sop again before any eop. Required response: proto_err=1 the cycle after the second sop is accepted, both beats are forwarded, and proto_err stays 1.
REQ-040 Stimulus: rst is asserted in LOCKED with out_if.valid=1. Required response: the next cycle shows out_if.valid=0, all ready=0, and after release input 0 wins a tie with input 1.
